blink_monitor: RTL and testbench

Receive-side checker for the blink LED protocol. Watches a `led` line and its companion `flg` wrap strobe, measures the interval between LED transitions and declares lock after consecutive in-tolerance intervals. Reports per-edge strobes, the last measured half-period and a one-cycle error pulse on any protocol violation. It sits beside the blink generator in self-check benches and on board-level loopback paths, clocked from the same clock.

---
 rtl/blink_pkg.sv | 16 +
 rtl/blink_interval_ctr.sv | 77 +++++++
 rtl/blink_monitor.sv | 145 ++++++++++++++
 tb/tb_blink_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the blink LED protocol receive-side checker.
//   blink_mon_state_t : monitor FSM states (IDLE, MEASURE, LOCKED)
//   nominal_half()    : nominal LED half-period, 2^cbits cycles
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } blink_mon_state_t;

  function automatic int unsigned nominal_half(input int unsigned cbits);
    return 32'd1 << cbits;
  endfunction

endpackage

// File: rtl/blink_interval_ctr.sv
// Edge detector and interval measurement for the blink monitor.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   i_led     in   LED line (same clock domain)
//   o_edge    out  LED differs from its registered copy this cycle
//   o_cnt     out  cycles since the previous edge, saturating
//   o_match   out  o_cnt within TOL of the nominal half-period
//   o_timeout out  single-cycle strobe when a gap overruns the window
module blink_interval_ctr
  import blink_pkg::*;
#(
  parameter int unsigned CBITS = 12,
  parameter int unsigned TOL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_led,
  output logic             o_edge,
  output logic [CBITS:0]   o_cnt,
  output logic             o_match,
  output logic             o_timeout
);

  localparam int unsigned CW   = CBITS + 1;
  localparam int unsigned NOM  = nominal_half(CBITS);
  // Comparisons are made one bit wider than the counter so that
  // nominal +/- tolerance and the timeout threshold never wrap.
  localparam logic [CW:0] NOM_X = (CW+1)'(NOM);
  localparam logic [CW:0] TOL_X = (CW+1)'(TOL);
  localparam logic [CW:0] TO_X  = (CW+1)'(NOM + TOL + 1);

  logic                 r_led_q;
  logic [CW-1:0]        r_cnt;
  logic                 r_to_fired;
  logic                 w_edge;
  logic [CW:0]          w_cnt_x;
  logic signed [CW:0]   w_diff;
  logic [CW:0]          w_abs;
  logic                 w_timeout;

  assign w_edge  = (i_led != r_led_q);
  assign w_cnt_x = {1'b0, r_cnt};
  assign w_diff  = $signed(w_cnt_x) - $signed(NOM_X);
  assign w_abs   = w_diff[CW] ? $unsigned(-w_diff) : $unsigned(w_diff);

  // r_to_fired keeps the strobe to one pulse per gap even when the
  // threshold coincides with the saturation value and cnt sits on it.
  assign w_timeout = !w_edge && (w_cnt_x == TO_X) && !r_to_fired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led_q    <= 1'b0;
      r_cnt      <= '0;
      r_to_fired <= 1'b0;
    end else begin
      r_led_q <= i_led;
      if (w_edge) begin
        r_cnt      <= CW'(1);
        r_to_fired <= 1'b0;
      end else begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_timeout) begin
          r_to_fired <= 1'b1;
        end
      end
    end
  end

  assign o_edge    = w_edge;
  assign o_cnt     = r_cnt;
  assign o_match   = (w_abs <= TOL_X);
  assign o_timeout = w_timeout;

endmodule

// File: rtl/blink_monitor.sv
// Receive-side checker for the blink LED protocol. Measures LED
// edge-to-edge intervals, locks after LOCK_CNT consecutive good
// intervals and flags mismatches, timeouts and missing wrap strobes.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   led_in      in   LED line from the generator
//   flg_in      in   generator wrap strobe, one cycle before each toggle
//   locked      out  high while in LOCKED
//   edge_p      out  one-cycle pulse per LED transition
//   err_p       out  one-cycle pulse per protocol violation
//   half_period out  last measured edge-to-edge interval
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned CBITS    = 12,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  input  logic           flg_in,
  output logic           locked,
  output logic           edge_p,
  output logic           err_p,
  output logic [CBITS:0] half_period
);

  localparam logic [3:0] LOCK4 = 4'(LOCK_CNT);

  blink_mon_state_t r_state;
  blink_mon_state_t w_state_nxt;
  logic             r_flg_q;
  logic [3:0]       r_good;
  logic [3:0]       w_good_nxt;
  logic             w_err_nxt;
  logic [CBITS:0]   w_hp_nxt;
  logic             r_locked;
  logic             r_edge_p;
  logic             r_err_p;
  logic [CBITS:0]   r_half_period;

  logic             w_edge;
  logic [CBITS:0]   w_cnt;
  logic             w_match;
  logic             w_timeout;

  blink_interval_ctr #(
    .CBITS (CBITS),
    .TOL   (TOL)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_led     (led_in),
    .o_edge    (w_edge),
    .o_cnt     (w_cnt),
    .o_match   (w_match),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err_nxt   = 1'b0;
    w_hp_nxt    = r_half_period;
    unique case (r_state)
      IDLE: begin
        // First edge after a gap only starts measurement; there is no
        // previous edge to measure against.
        if (w_edge) begin
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (w_edge) begin
          w_hp_nxt = w_cnt;
          if (w_match) begin
            w_good_nxt = r_good + 4'd1;
            if (r_good + 4'd1 == LOCK4) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_err_nxt  = 1'b1;
            w_good_nxt = 4'd0;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_good_nxt  = 4'd0;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          w_hp_nxt = w_cnt;
          // Bad interval and missing strobe share one error pulse.
          if (!w_match || !r_flg_q) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = MEASURE;
            w_good_nxt  = 4'd0;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
          w_good_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_good_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flg_q       <= 1'b0;
      r_good        <= 4'd0;
      r_locked      <= 1'b0;
      r_edge_p      <= 1'b0;
      r_err_p       <= 1'b0;
      r_half_period <= '0;
    end else begin
      r_flg_q       <= flg_in;
      r_good        <= w_good_nxt;
      r_locked      <= (w_state_nxt == LOCKED);
      r_edge_p      <= w_edge;
      r_err_p       <= w_err_nxt;
      r_half_period <= w_hp_nxt;
    end
  end

  assign locked      = r_locked;
  assign edge_p      = r_edge_p;
  assign err_p       = r_err_p;
  assign half_period = r_half_period;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with CBITS=4 (nominal 16), TOL=1,
// LOCK_CNT=3.
module tb_blink_monitor;
  import blink_pkg::*;

  localparam int unsigned CBITS    = 4;
  localparam int unsigned TOL      = 1;
  localparam int unsigned LOCK_CNT = 3;

  logic           clk    = 1'b0;
  logic           rst    = 1'b0;
  logic           led_in = 1'b0;
  logic           flg_in = 1'b0;
  logic           locked;
  logic           edge_p;
  logic           err_p;
  logic [CBITS:0] half_period;

  int   n_checks = 0;
  int   n_errors = 0;
  logic cur_led  = 1'b0;

  // One LED half-period: hold for len-1 cycles (strobe in the last one
  // if flg), toggle, then expect these outputs in the following cycle.
  typedef struct {
    int len;
    bit flg;
    bit exp_err;
    bit exp_lock;
    int exp_hp;
  } vec_t;

  vec_t vecs[26];

  always #5 clk = ~clk;

  blink_monitor #(
    .CBITS    (CBITS),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .led_in      (led_in),
    .flg_in      (flg_in),
    .locked      (locked),
    .edge_p      (edge_p),
    .err_p       (err_p),
    .half_period (half_period)
  );

  function automatic vec_t mk(input int len, input bit flg, input bit err,
                              input bit lock, input int hp);
    vec_t v;
    v.len = len; v.flg = flg; v.exp_err = err; v.exp_lock = lock; v.exp_hp = hp;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic led, input logic flg);
    led_in = led;
    flg_in = flg;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int e_edge, input int e_err,
                            input int e_lock, input int e_hp);
    check({tag, " edge_p"}, int'(edge_p), e_edge);
    check({tag, " err_p"}, int'(err_p), e_err);
    check({tag, " locked"}, int'(locked), e_lock);
    check({tag, " half_period"}, int'(half_period), e_hp);
  endtask

  task automatic send_interval(input int idx);
    vec_t v;
    int   mid_err;
    int   mid_edge;
    v        = vecs[idx];
    mid_err  = 0;
    mid_edge = 0;
    for (int k = 1; k < v.len; k++) begin
      step(cur_led, v.flg && (k == v.len - 1));
      mid_err  += int'(err_p);
      mid_edge += int'(edge_p);
    end
    cur_led = ~cur_led;
    step(cur_led, 1'b0);
    check($sformatf("iv%0d gap err_p", idx), mid_err, 0);
    check($sformatf("iv%0d gap edge_p", idx), mid_edge, 0);
    check_outs($sformatf("iv%0d", idx), 1, int'(v.exp_err), int'(v.exp_lock), v.exp_hp);
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_interval(i);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;

    // Clean lock, tolerance edges, mismatch, strobe violations.
    vecs[0]  = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[1]  = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[2]  = mk(16, 1'b1, 1'b0, 1'b1, 16);
    vecs[3]  = mk(16, 1'b1, 1'b0, 1'b1, 16);
    vecs[4]  = mk(15, 1'b1, 1'b0, 1'b1, 15);
    vecs[5]  = mk(17, 1'b1, 1'b0, 1'b1, 17);
    vecs[6]  = mk(18, 1'b1, 1'b1, 1'b0, 18);
    vecs[7]  = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[8]  = mk(15, 1'b1, 1'b0, 1'b0, 15);
    vecs[9]  = mk(17, 1'b1, 1'b0, 1'b1, 17);
    vecs[10] = mk(16, 1'b0, 1'b1, 1'b0, 16);
    vecs[11] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[12] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[13] = mk(16, 1'b1, 1'b0, 1'b1, 16);
    vecs[14] = mk(18, 1'b0, 1'b1, 1'b0, 18);
    vecs[15] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[16] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[17] = mk(16, 1'b1, 1'b0, 1'b1, 16);
    // Re-lock after timeout.
    vecs[18] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[19] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[20] = mk(16, 1'b1, 1'b0, 1'b1, 16);
    // Re-lock after reset.
    vecs[21] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[22] = mk(16, 1'b1, 1'b0, 1'b0, 16);
    vecs[23] = mk(16, 1'b1, 1'b0, 1'b1, 16);
    // Drop to MEASURE, then first compare after the saturation gap.
    vecs[24] = mk(16, 1'b0, 1'b1, 1'b0, 16);
    vecs[25] = mk(17, 1'b1, 1'b0, 1'b0, 17);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    #3 rst = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check_outs("idle", 0, 0, 0, 0);

    // First edge from IDLE: pulse, no compare.
    cur_led = 1'b1;
    step(cur_led, 1'b0);
    check_outs("first edge", 1, 0, 0, 0);

    run_table(0, 17);

    // Timeout while locked: err_p 18 cycles after the edge, plus one.
    stray = 0;
    for (int k = 1; k < 30; k++) begin
      step(cur_led, 1'b0);
      if (k == 17) begin
        check("to k17 err_p", int'(err_p), 0);
        check("to k17 locked", int'(locked), 1);
      end else if (k == 18) begin
        check("to k18 err_p", int'(err_p), 1);
        check("to k18 locked", int'(locked), 0);
        check("to k18 state", int'(dut.r_state), int'(IDLE));
      end else begin
        stray += int'(err_p);
      end
    end
    check("to stray err_p", stray, 0);
    cur_led = ~cur_led;
    step(cur_led, 1'b0);
    check_outs("to next edge", 1, 0, 0, 16);

    run_table(18, 20);

    // Asynchronous reset while locked; LED left high through release.
    #3 rst = 1'b0;
    #1;
    check_outs("async rst", 0, 0, 0, 0);
    cur_led = 1'b1;
    led_in  = 1'b1;
    flg_in  = 1'b0;
    @(posedge clk);
    #4 rst = 1'b1;
    step(cur_led, 1'b0);
    check_outs("post rst edge", 1, 0, 0, 0);
    run_table(21, 23);

    run_table(24, 24);

    // Saturation: gap of 40 from MEASURE, timeout silently to IDLE.
    stray = 0;
    for (int k = 1; k < 40; k++) begin
      step(cur_led, 1'b0);
      stray += int'(err_p);
      if (k == 18) check("sat state", int'(dut.r_state), int'(IDLE));
    end
    check("sat cnt", int'(dut.w_cnt), 31);
    check("sat stray err_p", stray, 0);
    cur_led = ~cur_led;
    step(cur_led, 1'b0);
    check_outs("sat edge", 1, 0, 0, 16);

    run_table(25, 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
